// File: rtl/fcs_append_ctrl.sv
// Streaming Ethernet FCS appender: forwards payload bytes, optionally zero-pads short
// frames up to MIN_LEN, then appends the 4-byte IEEE 802.3 CRC-32 in wire order.
module fcs_append_ctrl #(
    parameter int PAD_EN  = 1,
    parameter int MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

    localparam logic [31:0] POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic        adv;
    logic        accept;
    logic [15:0] cnt_inc;
    logic [16:0] cnt_plus1;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // MSB-first engine fed with the bit-reversed byte, i.e. the byte goes out LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic [7:0]  b;
        c = crc;
        b = bitrev8(data);
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv && (state_q == ST_DATA) && rst;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign cnt_plus1 = {1'b0, cnt_q} + 17'd1;
    assign fcs       = ~bitrev32(crc_q);

    always_comb begin
        case (idx_q)
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (adv) begin
            case (state_q)
                ST_DATA: begin
                    out_last_d = 1'b0;
                    if (accept) begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        crc_d       = crc_byte(crc_q, in_data);
                        cnt_d       = cnt_inc;
                        if (in_last) begin
                            idx_d = 2'd0;
                            if ((PAD_EN != 0) && (cnt_plus1 < MIN_LEN_W)) state_d = ST_PAD;
                            else                                          state_d = ST_FCS;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_PAD: begin
                    out_data_d  = 8'h00;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    crc_d       = crc_byte(crc_q, 8'h00);
                    cnt_d       = cnt_inc;
                    if (cnt_plus1 >= MIN_LEN_W) begin
                        state_d = ST_FCS;
                        idx_d   = 2'd0;
                    end
                end
                ST_FCS: begin
                    out_data_d  = fcs_byte;
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == 2'd3);
                    if (idx_q == 2'd3) begin
                        state_d = ST_DATA;
                        idx_d   = 2'd0;
                        cnt_d   = 16'd0;
                        crc_d   = CRC_INIT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                default: begin
                    state_d     = ST_DATA;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DATA;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            crc_q       <= CRC_INIT;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_DATA) || (cnt_q != 16'd0);

endmodule

// File: doc/fcs_append_ctrl.md
FCS_APPEND_CTRL -- requirements
Module: fcs_append_ctrl

Interface
REQ-001 SHALL have parameter PAD_EN, default 1, meaning: when 1, frames shorter than MIN_LEN are zero-padded before the FCS.
REQ-002 SHALL have parameter MIN_LEN, default 60, meaning: minimum pre-FCS byte count when padding (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is asynchronous and active-low (0 = reset).
REQ-005 SHALL have port in_data, input, 8, payload byte.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-007 SHALL have port in_last, input, 1, meaning the byte is the final payload byte of the frame.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts the byte this cycle.
REQ-009 SHALL have port out_data, output, 8, output byte (payload, pad or FCS).
REQ-010 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-011 SHALL have port out_last, output, 1, meaning the byte is the final FCS byte.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream accepts the byte.
REQ-013 SHALL have port busy, output, 1, meaning the state is not DATA or byte_cnt is nonzero.

Function
REQ-014 SHALL implement the states DATA, PAD and FCS, plus a 2-bit FCS index, a 16-bit byte_cnt and a 32-bit crc register.
REQ-015 SHALL define adv = !out_valid | out_ready, and load out_data, out_valid and out_last only when adv = 1.
REQ-016 SHALL drive in_ready = adv & (state == DATA), combinationally.
REQ-017 SHALL, in DATA, forward an accepted byte to out_data with out_valid = 1 and out_last = 0, and increment byte_cnt, saturating at 0xFFFF.
REQ-018 SHALL update crc on every payload and pad byte using the IEEE 802.3 CRC-32 byte update (polynomial 0x04C11DB7), with the byte presented bit-reversed (in bit i maps to engine bit 7-i).
REQ-019 SHALL apply the following transitions on an accepted byte with in_last = 1:
  - to PAD if PAD_EN = 1 and byte_cnt+1 < MIN_LEN;
  - otherwise to FCS with index 0.
REQ-020 SHALL, in PAD, emit 0x00 on each adv cycle, update crc and increment byte_cnt, and enter FCS when the emitted pad byte brings byte_cnt to MIN_LEN.
REQ-021 SHALL, in FCS, define fcs = ~bitrev32(crc) and emit fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24] for index 0..3 on successive adv cycles.
REQ-022 SHALL set out_last = 1 on FCS index 3, and on that cycle return to DATA with crc = 0xFFFFFFFF and byte_cnt = 0.
REQ-023 SHALL let a new frame's first byte be accepted on the cycle after FCS index 3 is loaded, with no idle cycle required.
REQ-024 SHALL treat a byte with in_valid = 1 and in_last = 1 as the first byte of a frame, forming a 1-byte frame.
REQ-025 SHALL ignore in_valid while in PAD or FCS, because in_ready = 0 there.
REQ-026 SHALL hold out_data, out_valid and out_last stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL clear out_valid when adv = 1 in DATA and no byte is accepted.
REQ-028 SHALL add no latency beyond one output register stage: an input byte accepted in cycle n appears on out_data in cycle n+1.
REQ-029 SHALL, when byte_cnt saturates at 0xFFFF, still compute the CRC correctly and append the FCS.

Reset
REQ-030 SHALL, while rst = 0, asynchronously force:
  - state = DATA, index = 0, byte_cnt = 0, crc = 0xFFFFFFFF;
  - out_valid = 0, out_last = 0, out_data = 0x00, busy = 0.
REQ-031 SHALL drive in_ready = 0 while rst = 0.
REQ-032 SHALL discard a frame in progress when rst is asserted mid-frame, emitting no terminating FCS, and SHALL accept a new frame from the first clk edge after rst deasserts.

Verification
REQ-033 SHALL verify the known-answer case: with PAD_EN = 0, send ASCII "123456789" (last on '9') with out_ready = 1 -> output is the 9 bytes followed by 0x26, 0x39, 0xF4, 0xCB, with out_last on 0xCB, 13 output beats, each byte one cycle after acceptance.
REQ-034 SHALL verify padding: with PAD_EN = 1 and MIN_LEN = 60, send a 1-byte frame 0xAA -> output is 0xAA, 59 × 0x00, then 4 FCS bytes matching the software CRC-32 of that 60-byte buffer; 64 beats total.
REQ-035 SHALL verify backpressure: hold out_ready = 0 for 5 cycles during payload and again during FCS index 2 -> outputs stay stable, in_ready = 0 throughout, and the byte sequence is identical to the case without stalls.
REQ-036 SHALL verify back-to-back frames: send two "123456789" frames with in_valid held high -> the second frame's first byte is accepted the cycle after the first frame's out_last load, and both FCS values equal 0xCBF43926 in wire order.
REQ-037 SHALL verify reset mid-frame: assert rst = 0 after 5 payload bytes -> out_valid = 0 immediately; after release, a new "123456789" frame yields the correct FCS.
REQ-038 SHALL verify a frame at exactly MIN_LEN: with PAD_EN = 1, send 60 payload bytes -> no pad bytes are inserted and the FCS follows the 60th byte directly.
